pad_trigger_holdoff: RTL
========================

// Module: pad_trigger_holdoff
// PURPOSE
//  Downstream of the logic-pad hit generator. Consumes its qualified single-bit hit (pad_hited_clear).
//  Applies a programmable hold-off (dead time) after each accepted hit and timestamps each accepted hit
//  with a free-running cycle counter. Buffers timestamps in a small FIFO for the trigger readout
//  via valid/ready.
// PARAMETERS
//  TS_WIDTH    12  width of free-running timestamp counter and of trig_timestamp
//  HOLD_WIDTH  8   width of holdoff_cycles
//  FIFO_DEPTH  4   trigger FIFO entries, power of two, >=2
// PORTS
//  clk             in   1           single clock; all logic on posedge
//  rst             in   1           synchronous, active-high reset
//  enable          in   1           0: hits ignored; FIFO still drains
//  hit_in          in   1           qualified pad hit pulse (pad_hited_clear upstream)
//  holdoff_cycles  in   HOLD_WIDTH  dead cycles after an accepted hit; sampled at acceptance
//  overflow_clr    in   1           clears sticky overflow
//  trig_valid      out  1           FIFO non-empty
//  trig_ready      in   1           consumer pops head when trig_valid&trig_ready
//  trig_timestamp  out  TS_WIDTH    head-of-FIFO timestamp
//  trig_overflow   out  1           sticky: accepted hit dropped because FIFO full
//  holdoff_busy    out  1           1 while in HOLDOFF
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): ts_cnt=0, state=IDLE, hold_cnt=0, FIFO empty.
//    trig_valid=0, trig_timestamp=0, trig_overflow=0, holdoff_busy=0.
//    Reset mid-operation discards all FIFO contents and any hold-off in progress.
//  - ts_cnt increments every non-reset cycle; wraps 2^TS_WIDTH-1 -> 0, no flag.
//  - FSM IDLE: hit_in&enable => accept.
//    Entry = ts_cnt of the hit cycle. If holdoff_cycles!=0, load hold_cnt=holdoff_cycles and go HOLDOFF; else stay IDLE.
//    With holdoff_cycles=0, back-to-back hits are each accepted.
//  - FSM HOLDOFF: hit_in ignored. hold_cnt decrements each cycle; at hold_cnt==1 -> IDLE next cycle.
//    Hold-off therefore blocks exactly holdoff_cycles cycles after the accept cycle.
//  - enable deasserted in HOLDOFF: countdown continues; no effect.
//  - Latency: accepted hit at posedge N => entry visible (trig_valid=1, trig_timestamp) after posedge N+1.
//  - FIFO push on accept. Pop on trig_valid&trig_ready.
//  - Full with pop in the same cycle: push is accepted.
//  - Full without pop: entry dropped, trig_overflow<=1. Hold-off is still entered.
//  - Push into empty FIFO with trig_ready=1: no same-cycle bypass; pop occurs the next cycle.
//  - trig_timestamp holds its value when empty (stale, don't-care). Stable while trig_valid&!trig_ready.
//  - overflow_clr and a new overflow event in the same cycle: overflow wins (stays 1).
// CONFIGURATION
//  PAD_TRIG_HIT_COUNT_EN defined: adds outputs
//    accepted_cnt[31:0] — increments per accept, including dropped-on-full.
//    rejected_cnt[31:0] — increments per hit_in&enable seen in HOLDOFF.
//    Both saturate at all-ones, reset to 0, and clear on overflow_clr.
//  PAD_TRIG_HIT_COUNT_EN not defined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package pad_trig_pkg:
//    FSM state encoding (ST_IDLE, ST_HOLDOFF); default TS_WIDTH, HOLD_WIDTH, FIFO_DEPTH.
//  - Sub-module pad_trig_fifo:
//    sync FIFO, width TS_WIDTH, depth FIFO_DEPTH, registered output, push-when-full-with-pop allowed.
//  - Top holds ts_cnt, FSM, hold-off counter, overflow flag and optional counters.
// TESTING
//  1. holdoff=4, single hit at ts=10, ready=1 -> one entry ts=10, trig_valid high 1 cycle starting next cycle.
//  2. holdoff=4, hits at ts=20..27 every cycle -> entries ts=20, 25; hits at 21-24 and 26-27 rejected.
//     rejected_cnt=6 (with PAD_TRIG_HIT_COUNT_EN).
//  3. holdoff=0, ready=0, hits at 5 consecutive cycles, depth 4 -> 4 entries, 5th dropped, trig_overflow=1.
//     Then overflow_clr -> 0.
//  4. FIFO full, ready=1 and hit in the same cycle -> push accepted, no overflow, occupancy stays 4.
//  5. ts_cnt near 4095, hit at 4095 and (holdoff=0) at 0 -> timestamps 4095 then 0, in order.
//  6. rst asserted in HOLDOFF with 3 entries queued -> next cycle trig_valid=0, holdoff_busy=0, ts restarts at 0.
//     A hit 2 cycles later is accepted.

Source files
------------

// File: rtl/pad_trig_pkg.sv
// Shared definitions for the pad trigger hold-off block: FSM state encoding
// and default sizing parameters.
package pad_trig_pkg;

  localparam int TS_WIDTH_DEF   = 12;
  localparam int HOLD_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } trig_state_e;

endpackage

// File: rtl/pad_trig_fifo.sv
// Synchronous trigger FIFO with a registered head output. A push while full
// is accepted when a pop happens in the same cycle. There is no same-cycle
// bypass: a word pushed into an empty FIFO becomes visible after the edge.
module pad_trig_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              valid,
  output logic              full,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              push_eff, pop_eff;

  assign valid    = (count_q != '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop & valid;
  assign push_eff = push & (~full | pop_eff);
  assign rdata    = dout_q;

  // Next pointers, occupancy and head-of-queue value.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_eff);
    rd_ptr_d = rd_ptr_q + AW'(pop_eff);
    count_d  = count_q + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
    dout_d   = dout_q;
    if (pop_eff) begin
      if (count_d != '0) begin
        // After a pop from a single-entry queue the new head is the word
        // being written this very cycle, which is not in memory yet.
        if (push_eff && (rd_ptr_d == wr_ptr_q)) begin
          dout_d = wdata;
        end else begin
          dout_d = mem_q[rd_ptr_d];
        end
      end
    end else if (push_eff && !valid) begin
      dout_d = wdata;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer, occupancy and head register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/pad_trigger_holdoff.sv
// Trigger hold-off and timestamping for qualified pad hits. Each accepted
// hit is stamped with a free-running cycle counter and queued for readout;
// a programmable dead time follows every accepted hit.
// Optional feature macro: PAD_TRIG_HIT_COUNT_EN adds saturating
// accepted_cnt / rejected_cnt outputs.
module pad_trigger_holdoff
  import pad_trig_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int HOLD_WIDTH = HOLD_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  hit_in,
  input  logic [HOLD_WIDTH-1:0] holdoff_cycles,
  input  logic                  overflow_clr,
  output logic                  trig_valid,
  input  logic                  trig_ready,
  output logic [TS_WIDTH-1:0]   trig_timestamp,
  output logic                  trig_overflow,
  output logic                  holdoff_busy
`ifdef PAD_TRIG_HIT_COUNT_EN
  ,
  output logic [31:0]           accepted_cnt,
  output logic [31:0]           rejected_cnt
`endif
);

  trig_state_e           state_q, state_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  ovf_q, ovf_d;
  logic                  accept, drop, pop, fifo_full;

  assign accept       = (state_q == ST_IDLE) & hit_in & enable;
  assign pop          = trig_valid & trig_ready;
  assign drop         = accept & fifo_full & ~pop;
  assign holdoff_busy = (state_q == ST_HOLDOFF);
  assign trig_overflow = ovf_q;

  // Free-running timestamp counter; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  // Hold-off FSM: dead time of exactly holdoff_cycles after each accept.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (holdoff_cycles != '0)) begin
          state_d = ST_HOLDOFF;
          hold_d  = holdoff_cycles;
        end
      end
      ST_HOLDOFF: begin
        if (hold_q == HOLD_WIDTH'(1)) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q - HOLD_WIDTH'(1);
        end
      end
    endcase
  end

  // FSM state and hold-off counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps it set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  pad_trig_fifo #(
    .DATA_W (TS_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (ts_q),
    .valid (trig_valid),
    .full  (fifo_full),
    .rdata (trig_timestamp)
  );

`ifdef PAD_TRIG_HIT_COUNT_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] rej_q, rej_d;
  logic        reject;

  assign reject       = (state_q == ST_HOLDOFF) & hit_in & enable;
  assign accepted_cnt = acc_q;
  assign rejected_cnt = rej_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    if (inc && (v != '1)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

  // Hit statistics; clearing takes priority over counting.
  always_comb begin
    acc_d = sat_inc(acc_q, accept);
    rej_d = sat_inc(rej_q, reject);
    if (overflow_clr) begin
      acc_d = '0;
      rej_d = '0;
    end
  end

  // Hit statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      rej_q <= '0;
    end else begin
      acc_q <= acc_d;
      rej_q <= rej_d;
    end
  end
`endif

endmodule
